// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential/branch/jump/call/ret next-PC selection
// with a circular return-address stack that overwrites its oldest entry when full.
module pc_unit #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int unsigned       INC       = 1,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           en,
  input  logic                           branch,
  input  logic [WIDTH-1:0]               branch_off,
  input  logic                           jump,
  input  logic                           call,
  input  logic [WIDTH-1:0]               jump_target,
  input  logic                           ret,
  output logic [WIDTH-1:0]               q,
  output logic [WIDTH-1:0]               pc_plus,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_ovf,
  output logic                           ras_err
);

  localparam int unsigned      CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam int unsigned      PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             push;
  logic [PTR_W-1:0] sp_inc, sp_dec;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  // sp_q is the next free slot; the top entry sits one below it (mod depth).
  assign pc_plus = q_q + WIDTH'(INC);
  assign sp_inc  = (sp_q == PTR_MAX) ? '0 : sp_q + PTR_W'(1);
  assign sp_dec  = (sp_q == '0) ? PTR_MAX : sp_q - PTR_W'(1);

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    err_d = 1'b0;
    push  = 1'b0;
    if (en) begin
      if (ret) begin
        if (cnt_q != '0) begin
          q_d   = ras_q[sp_dec];
          sp_d  = sp_dec;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          q_d   = pc_plus;
          err_d = 1'b1;
        end
      end else if (call) begin
        q_d  = jump_target;
        push = 1'b1;
        sp_d = sp_inc;
        // When full, the slot at sp_q holds the oldest entry and is recycled.
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_W'(1);
      end else if (jump) begin
        q_d = jump_target;
      end else if (branch) begin
        q_d = pc_plus + branch_off;
      end else begin
        q_d = pc_plus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q   <= RESET_VEC;
      cnt_q <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  // Entry contents are never reset; ras_count alone decides what is live.
  for (genvar i = 0; i < int'(RAS_DEPTH); i++) begin : g_ras
    always_ff @(posedge clk) begin
      if (!clr && push && (sp_q == PTR_W'(i))) ras_q[i] <= pc_plus;
    end
  end

  assign q         = q_q;
  assign ras_count = cnt_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);
  assign ras_ovf   = ovf_q;
  assign ras_err   = err_q;

endmodule
